ser_port_router: RTL and testbench
==================================

SER_PORT_ROUTER -- requirements
Module: ser_port_router

Interface
REQ-001 Parameter NPORT, default 4, number of output ports; SHALL be a power of two, at least 2.
REQ-002 Parameter SELW, default $clog2(NPORT), port-select field width in bits.
REQ-003 Parameter LENW, default 4, length field width in bits; max payload is 2^LENW-1 bits.
REQ-004 Parameter PARITY_EN, default 1; when 1, each frame carries one even-parity bit after the payload.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 clkEn  in  1  sample enable; the FSM advances only on edges with clkEn=1.
REQ-008 SerIn  in  1  serial input, idle high.
REQ-009 PortOut  out  NPORT  registered routed data; only the selected bit may be non-zero.
REQ-010 SerOutValid  out  1  registered; high while PortOut carries a payload bit.
REQ-011 Done  out  1  end-of-frame pulse.
REQ-012 ParityErr  out  1  parity mismatch flag, valid only with Done.
REQ-013 Busy  out  1  high whenever state is not IDLE.
REQ-014 RemCount  out  LENW  payload bits still to receive (display feed).

Function
REQ-015 Frame format: start bit 0; SELW port bits, MSB first; LENW length bits L, MSB first; L payload bits; one parity bit if PARITY_EN=1.
REQ-016 States SHALL be IDLE, PORT, LEN, DATA, PAR, DONE.
REQ-017 IDLE: SerIn=0 sampled -> PORT, bit counter cleared; SerIn=1 -> stay.
REQ-018 PORT: shift SELW bits into sel; after the last bit -> LEN.
REQ-019 LEN: shift LENW bits; after the last bit, load RemCount=L; go to DATA if L!=0, else PAR (PARITY_EN=1) or DONE.
REQ-020 DATA: on each sample, PortOut[sel]<=SerIn, other bits <=0, SerOutValid<=1, RemCount<=RemCount-1, parity accumulator ^= SerIn.
REQ-021 DATA exits to PAR (or DONE when PARITY_EN=0) on the sample that takes RemCount from 1 to 0.
REQ-022 SerOutValid SHALL be high for exactly L enabled cycles, each one clock after its payload sample; latency SerIn->PortOut is 1 clock.
REQ-023 The next enabled edge with no payload sample clears SerOutValid to 0 and PortOut to 0.
REQ-024 PAR: sample parity bit; ParityErr<=accumulator^SerIn; -> DONE.
REQ-025 DONE: Done=1 for the cycle spent in DONE; on the next enabled edge -> IDLE, and Done and ParityErr clear to 0. SerIn is ignored in DONE, so a start bit there is not detected.
REQ-026 clkEn=0 edge: state, counters, sel, RemCount, PortOut and ParityErr hold; SerOutValid clears to 0.
REQ-027 The parity accumulator clears on entry to PORT; for L=0 the expected parity is 0.
REQ-028 sel SHALL index PortOut directly; no out-of-range case exists because NPORT=2^SELW.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, PortOut=0, SerOutValid=0, Done=0, ParityErr=0, Busy=0, RemCount=0, sel=0, counters=0.
REQ-030 Reset mid-frame aborts the frame with no Done; the first frame after rst=1 SHALL decode correctly.

Verification (NPORT=4, LENW=4, PARITY_EN=1, clkEn=1 unless stated)
REQ-031 Input 0 | 1,1 | 0,0,1,1 | 1,0,1 | 0 -> PortOut[3] = 1,0,1 on three consecutive cycles, PortOut[2:0]=0, SerOutValid high 3 cycles, RemCount 3->0, Done pulse, ParityErr=0.
REQ-032 Same frame with parity bit 1 -> Done pulse with ParityErr=1; both 0 on the following cycle.
REQ-033 Input 0 | 0,1 | 0,0,0,0 | 0 -> SerOutValid never high, Done pulse, ParityErr=0, Busy high from PORT through DONE.
REQ-034 clkEn=0 for 2 cycles after the 2nd of 5 payload bits -> RemCount holds 3, SerOutValid low during the gap, all 5 bits delivered, Done after parity.
REQ-035 rst=0 after the 2nd of 6 payload bits -> all outputs 0 at once, Busy=0; a following valid frame for port 1 with L=2 routes correctly.
REQ-036 NPORT=8 build: port bits 1,0,1 -> payload appears only on PortOut[5].

Source files
------------

// File: rtl/ser_port_router.sv
// Purpose : serial frame decoder; routes each payload bit to the port named in the frame header.
// Latency : 1 clock from a sampled payload bit on SerIn to PortOut/SerOutValid.
// Backpressure: none; clkEn gates sampling, and SerOutValid drops on any edge without a payload sample.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   clkEn           sample enable; the frame decoder only advances on enabled edges
//   SerIn           serial input, idle high
//   PortOut         routed payload bit; only the selected port bit may be set
//   SerOutValid     high for the cycle after each payload sample
//   Done            high for the one state spent at end of frame
//   ParityErr       even-parity mismatch, meaningful while Done is high
//   Busy            high whenever a frame is in progress
//   RemCount        payload bits still to be received
//
// Frame: start 0 | SELW port bits MSB first | LENW length bits MSB first | L payload bits | parity bit
// (parity bit only when PARITY_EN=1). LENW must be at least 2.
module ser_port_router #(
    parameter int NPORT     = 4,
    parameter int SELW      = $clog2(NPORT),
    parameter int LENW      = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    input  logic             SerIn,
    output logic [NPORT-1:0] PortOut,
    output logic             SerOutValid,
    output logic             Done,
    output logic             ParityErr,
    output logic             Busy,
    output logic [LENW-1:0]  RemCount
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PORT = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_PAR  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // One counter serves both header fields, so it must reach the wider one.
    localparam int MAXW = (SELW > LENW) ? SELW : LENW;
    localparam int CNTW = $clog2(MAXW + 1);

    logic [2:0]      state;
    logic [CNTW-1:0] bit_cnt;
    logic [SELW-1:0] sel;
    logic [LENW-2:0] len_sh;   // all but the final length bit, which arrives on SerIn
    logic            par_acc;

    logic [SELW-1:0]  sel_nxt;
    logic [LENW-1:0]  len_nxt;
    logic [NPORT-1:0] port_onehot;
    logic [2:0]       after_data;
    logic             last_sel_bit;
    logic             last_len_bit;

    always_comb begin
        sel_nxt      = SELW'({sel, SerIn});
        len_nxt      = {len_sh, SerIn};
        // NPORT is 2**SELW, so every sel value names a real port.
        port_onehot  = NPORT'(1) << sel;
        after_data   = PARITY_EN ? S_PAR : S_DONE;
        last_sel_bit = (bit_cnt == CNTW'(SELW - 1));
        last_len_bit = (bit_cnt == CNTW'(LENW - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            sel         <= '0;
            len_sh      <= '0;
            par_acc     <= 1'b0;
            PortOut     <= '0;
            SerOutValid <= 1'b0;
            ParityErr   <= 1'b0;
            RemCount    <= '0;
        end else if (!clkEn) begin
            // Stalled edge: everything holds except the valid strobe.
            SerOutValid <= 1'b0;
        end else begin
            // Any enabled edge without a payload sample clears the routed output.
            PortOut     <= '0;
            SerOutValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!SerIn) begin
                        state   <= S_PORT;
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                    end
                end
                S_PORT: begin
                    sel <= sel_nxt;
                    if (last_sel_bit) begin
                        bit_cnt <= '0;
                        state   <= S_LEN;
                    end else begin
                        bit_cnt <= bit_cnt + CNTW'(1);
                    end
                end
                S_LEN: begin
                    len_sh <= len_nxt[LENW-2:0];
                    if (last_len_bit) begin
                        bit_cnt  <= '0;
                        RemCount <= len_nxt;
                        state    <= (len_nxt != '0) ? S_DATA : after_data;
                    end else begin
                        bit_cnt <= bit_cnt + CNTW'(1);
                    end
                end
                S_DATA: begin
                    PortOut     <= SerIn ? port_onehot : '0;
                    SerOutValid <= 1'b1;
                    RemCount    <= RemCount - LENW'(1);
                    par_acc     <= par_acc ^ SerIn;
                    if (RemCount == LENW'(1)) begin
                        state <= after_data;
                    end
                end
                S_PAR: begin
                    ParityErr <= par_acc ^ SerIn;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    // SerIn is deliberately ignored here; a start bit now is lost.
                    ParityErr <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign Done = (state == S_DONE);
    assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_ser_port_router.sv
// Purpose : self-checking bench for ser_port_router (4-port build plus an 8-port build).
// Latency : expectations are updated 1 ns after each rising edge and compared on the falling edge.
// Backpressure: clkEn gaps are inserted in the payload to exercise stalls.
module tb_ser_port_router;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkEn;
    logic       SerIn;
    logic [3:0] PortOut;
    logic       SerOutValid, Done, ParityErr, Busy;
    logic [3:0] RemCount;

    logic       en8, ser8;
    logic [7:0] pout8;
    logic       vld8, done8, perr8, busy8;
    logic [3:0] rem8;

    always #5 clk = ~clk;

    ser_port_router #(.NPORT(4), .LENW(4), .PARITY_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .clkEn(clkEn), .SerIn(SerIn),
        .PortOut(PortOut), .SerOutValid(SerOutValid), .Done(Done),
        .ParityErr(ParityErr), .Busy(Busy), .RemCount(RemCount)
    );

    ser_port_router #(.NPORT(8), .LENW(4), .PARITY_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .clkEn(en8), .SerIn(ser8),
        .PortOut(pout8), .SerOutValid(vld8), .Done(done8),
        .ParityErr(perr8), .Busy(busy8), .RemCount(rem8)
    );

    int n_chk = 0;
    int n_err = 0;

    // Expected outputs of the 4-port build, derived from position within the frame.
    logic [3:0] e_pout = '0;
    logic       e_vld = 1'b0, e_done = 1'b0, e_perr = 1'b0, e_busy = 1'b0;
    logic [3:0] e_rem = '0;
    logic       chk_on = 1'b0;

    // Observations gathered for the per-frame literal checks.
    int          valid_cnt, done_cnt;
    logic [15:0] cap;
    logic [3:0]  port_seen;
    logic        perr_at_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("PortOut",     32'(PortOut),     32'(e_pout));
            chk("SerOutValid", 32'(SerOutValid), 32'(e_vld));
            chk("Done",        32'(Done),        32'(e_done));
            chk("ParityErr",   32'(ParityErr),   32'(e_perr));
            chk("Busy",        32'(Busy),        32'(e_busy));
            chk("RemCount",    32'(RemCount),    32'(e_rem));
            if (SerOutValid === 1'b1) begin
                valid_cnt++;
                cap       = {cap[14:0], |PortOut};
                port_seen = port_seen | PortOut;
            end
            if (Done === 1'b1) begin
                done_cnt++;
                perr_at_done = ParityErr;
            end
        end
    end

    task automatic clear_obs();
        valid_cnt = 0; done_cnt = 0; cap = '0; port_seen = '0; perr_at_done = 1'b0;
    endtask

    task automatic drive(input logic s, input logic e);
        SerIn = s;
        clkEn = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1);
    endtask

    // Send one frame. pay[j] is the j-th payload bit sent. A stall of gap_n
    // disabled edges follows payload bit number gap_at (1-based; 0 = none).
    // abort_at >= 0 pulls reset after that many payload bits have been sent.
    task automatic send_frame(input int port, input int len, input logic [14:0] pay,
                              input bit flip_par, input int gap_at, input int gap_n,
                              input int abort_at);
        logic acc;
        logic [1:0] p;
        logic [3:0] l;
        acc = 1'b0;
        p = 2'(port);
        l = 4'(len);
        drive(1'b0, 1'b1);
        e_busy = 1'b1; e_vld = 1'b0; e_pout = '0;
        for (int i = 1; i >= 0; i--) drive(p[i], 1'b1);
        for (int i = 3; i >= 0; i--) begin
            drive(l[i], 1'b1);
            if (i == 0) e_rem = l;
        end
        for (int j = 0; j < len; j++) begin
            if (j == abort_at) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_PortOut",     32'(PortOut),     0);
                chk("rst_SerOutValid", 32'(SerOutValid), 0);
                chk("rst_Busy",        32'(Busy),        0);
                chk("rst_RemCount",    32'(RemCount),    0);
                chk("rst_Done",        32'(Done),        0);
                e_pout = '0; e_vld = 1'b0; e_done = 1'b0; e_perr = 1'b0;
                e_busy = 1'b0; e_rem = '0;
                @(posedge clk);
                #3 rst = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            drive(pay[j], 1'b1);
            e_pout = pay[j] ? (4'b0001 << port) : 4'b0000;
            e_vld  = 1'b1;
            e_rem  = 4'(len - 1 - j);
            acc    = acc ^ pay[j];
            if (j + 1 == gap_at) begin
                for (int g = 0; g < gap_n; g++) begin
                    drive(1'($urandom_range(1)), 1'b0);
                    e_vld = 1'b0;
                end
            end
        end
        drive(acc ^ flip_par, 1'b1);
        e_vld = 1'b0; e_pout = '0; e_perr = flip_par; e_done = 1'b1;
        // Start bit during the end-of-frame state must be ignored.
        drive(1'b0, 1'b1);
        e_done = 1'b0; e_perr = 1'b0; e_busy = 1'b0;
        idle(2);
    endtask

    initial begin
        logic b8 [11];
        rst = 1'b0; SerIn = 1'b1; clkEn = 1'b1; en8 = 1'b1; ser8 = 1'b1;
        #1;
        chk("reset_PortOut",   32'(PortOut),     0);
        chk("reset_Valid",     32'(SerOutValid), 0);
        chk("reset_Busy",      32'(Busy),        0);
        chk("reset_RemCount",  32'(RemCount),    0);
        chk("reset_ParityErr", 32'(ParityErr),   0);
        #2 rst = 1'b1;
        chk_on = 1'b1;
        idle(3);

        // Port 3, L=3, payload 1,0,1, good parity.
        clear_obs();
        send_frame(3, 3, 15'b101, 1'b0, 0, 0, -1);
        chk("f1_valid_cnt", 32'(valid_cnt), 3);
        chk("f1_bits",      32'(cap), 32'h5);
        chk("f1_port",      32'(port_seen), 32'h8);
        chk("f1_done_cnt",  32'(done_cnt), 1);
        chk("f1_perr",      32'(perr_at_done), 0);

        // Same frame, wrong parity bit.
        clear_obs();
        send_frame(3, 3, 15'b101, 1'b1, 0, 0, -1);
        chk("f2_perr",     32'(perr_at_done), 1);
        chk("f2_done_cnt", 32'(done_cnt), 1);

        // Port 1, L=0: no payload, parity 0.
        clear_obs();
        send_frame(1, 0, 15'b0, 1'b0, 0, 0, -1);
        chk("f3_valid_cnt", 32'(valid_cnt), 0);
        chk("f3_done_cnt",  32'(done_cnt), 1);
        chk("f3_perr",      32'(perr_at_done), 0);

        // Port 2, L=5, two stalled edges after the 2nd payload bit.
        clear_obs();
        send_frame(2, 5, 15'b01101, 1'b0, 2, 2, -1);
        chk("f4_valid_cnt", 32'(valid_cnt), 5);
        chk("f4_bits",      32'(cap), 32'b10110);
        chk("f4_port",      32'(port_seen), 32'h4);
        chk("f4_done_cnt",  32'(done_cnt), 1);

        // Port 0, L=6, reset after 2nd payload bit, then port 1, L=2.
        clear_obs();
        send_frame(0, 6, 15'b111111, 1'b0, 0, 0, 2);
        chk("f5_done_cnt", 32'(done_cnt), 0);
        idle(2);
        clear_obs();
        send_frame(1, 2, 15'b11, 1'b0, 0, 0, -1);
        chk("f6_valid_cnt", 32'(valid_cnt), 2);
        chk("f6_port",      32'(port_seen), 32'h2);
        chk("f6_perr",      32'(perr_at_done), 0);

        // Maximum length frame with random payload.
        clear_obs();
        send_frame(0, 15, 15'($urandom), 1'($urandom_range(1)), 7, 1, -1);
        chk("f7_valid_cnt", 32'(valid_cnt), 15);

        // 8-port build: port 1,0,1 (=5), L=2, payload 1,1, parity 0.
        chk_on = 1'b0;
        b8 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 11; k++) begin
            ser8 = b8[k];
            @(posedge clk);
            #1;
            if (k == 8 || k == 9) begin
                chk("p8_pout", 32'(pout8), 32'h20);
                chk("p8_vld",  32'(vld8), 1);
            end
            if (k == 9) chk("p8_rem", 32'(rem8), 0);
            if (k == 10) begin
                chk("p8_done", 32'(done8), 1);
                chk("p8_perr", 32'(perr8), 0);
                chk("p8_pout_clr", 32'(pout8), 0);
                chk("p8_busy", 32'(busy8), 1);
            end
        end
        ser8 = 1'b1;
        @(posedge clk);
        #1;
        chk("p8_idle", 32'(busy8), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
